lsu_ctrl: RTL and testbench
===========================

LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 SHALL have parameter XLEN, default 32, giving the data and address width.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-004 SHALL have port req_valid, input, 1: a core access request is present.
REQ-005 SHALL have port req_ready, output, 1: controller is in IDLE and accepts the request.
REQ-006 SHALL have port req_we, input, 1: 1 = store, 0 = load.
REQ-007 SHALL have port req_funct3, input, 3: access size/sign code (LB..LWU / SB..SD encodings from defines.v).
REQ-008 SHALL have ports req_addr and req_wdata, input, XLEN each: byte address and store data.
REQ-009 SHALL have ports resp_valid (output, 1), resp_rdata (output, XLEN) and resp_err (output, 1): completion pulse, load result and error flag.
REQ-010 SHALL have ports mem_req (output, 1), mem_we (output, 1), mem_addr (output, XLEN) and mem_wdata (output, XLEN): the memory-side request.
REQ-011 SHALL have ports mem_ack (input, 1) and mem_rdata (input, XLEN): memory completion and read data.

Function
REQ-012 SHALL instantiate the codebase lu and su units, driving s_byte from the latched addr[0] and funct3 from the latched req_funct3.
REQ-013 SHALL have FSM states IDLE, RD, WR and RESP; req_ready = (state==IDLE).
REQ-014 SHALL latch we, funct3, addr and wdata on the accept edge (req_valid && req_ready) and ignore req_* inputs at all other times.
REQ-015 SHALL transition as follows: load: IDLE->RD->RESP; SB/SH/SW: IDLE->RD->WR->RESP (read-modify-write); SD: IDLE->WR->RESP.
REQ-016 SHALL hold mem_req=1 throughout RD and WR, with mem_we=1 only in WR, mem_addr = latched addr with bit 0 cleared, and all mem outputs stable until mem_ack.
REQ-017 SHALL advance out of RD or WR on the edge where mem_ack=1; mem_ack outside RD/WR SHALL be ignored.
REQ-018 SHALL on mem_ack in RD latch mem_rdata into an internal word register; for loads, resp_rdata = lu output over that word.
REQ-019 SHALL drive mem_wdata in WR with the su output computed from data_l = the latched read word and data_in = the latched wdata.
REQ-020 SHALL assert resp_valid for exactly one cycle in RESP and then return to IDLE; there is no back-pressure on the response.
REQ-021 SHALL hold resp_rdata stable from RESP until the next accepted load, and SHALL drive resp_rdata = 0 for stores.
REQ-022 SHALL give a minimum latency, accept to resp_valid, of 2 cycles for loads and SD, and 3 cycles for SB/SH/SW, each plus memory wait cycles.
REQ-023 SHALL treat an undefined funct3 as a load or store that completes normally with resp_err=1 and no memory access (IDLE->RESP).

Reset
REQ-024 SHALL on rst=1 at a clock edge force IDLE and clear all outputs and the internal registers to 0, including mid-transaction; an outstanding mem_ack after reset SHALL be ignored.
REQ-025 SHALL have req_ready=1 in the first cycle after rst deasserts.

Configuration
REQ-026 SHALL support macro LSU_MISALIGN_TRAP_EN: when defined, LH/LHU/LW/LWU/SH/SW with addr[0]=1 SHALL go IDLE->RESP with resp_err=1, no mem_req and resp_rdata=0.
REQ-027 SHALL, when LSU_MISALIGN_TRAP_EN is undefined, ignore addr[0] for non-byte accesses, use the aligned word and keep resp_err=0 for defined funct3.

Verification
REQ-028 SHALL cover LB at addr 0x101 with mem_rdata=0x0000_80FF and 0-wait ack -> resp_rdata=0xFFFF_FF80 two cycles after accept.
REQ-029 SHALL cover SB at addr 0x201 with wdata 0xAB and read word 0x1234_5678 -> one read, then a write of 0x1234_AB78 to 0x200, resp_valid 3 cycles after accept.
REQ-030 SHALL cover SD with wdata 0xDEAD_BEEF -> a single write of 0xDEAD_BEEF with no read cycle.
REQ-031 SHALL cover 3 cycles of mem_ack wait in RD -> mem_req/mem_addr stable, req_ready=0 and resp_valid 5 cycles after accept.
REQ-032 SHALL cover rst asserted in WR -> next cycle IDLE with all outputs 0, and a late mem_ack produces no resp_valid.
REQ-033 SHALL cover LW at addr 0x3 with the macro defined -> resp_err=1 and no mem_req; without the macro -> a read of 0x2 with resp_err=0.

Source files
------------

// File: rtl/lsu_ctrl.sv
// Load/store controller: sequences loads, read-modify-write sub-word stores and full-word stores.
// Optional macro LSU_MISALIGN_TRAP_EN: trap misaligned half/word accesses with resp_err.
package lsu_pkg;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;
endpackage

// Load unit: extracts and extends the addressed field of a memory word.
module lu
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            s_byte_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] data_i,
  output logic [XLEN-1:0] data_o
);
  logic [7:0] b;

  // Select byte lane, then size/sign extend.
  always_comb begin
    b      = s_byte_i ? data_i[15:8] : data_i[7:0];
    data_o = '0;
    case (funct3_i)
      F3_B:    data_o = XLEN'($signed(b));
      F3_H:    data_o = XLEN'($signed(data_i[15:0]));
      F3_W:    data_o = XLEN'($signed(data_i[31:0]));
      F3_D:    data_o = data_i;
      F3_BU:   data_o = XLEN'(b);
      F3_HU:   data_o = XLEN'(data_i[15:0]);
      F3_WU:   data_o = XLEN'(data_i[31:0]);
      default: data_o = '0;
    endcase
  end
endmodule

// Store unit: merges store data into the previously read word.
module su
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            s_byte_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] data_l_i,
  input  logic [XLEN-1:0] data_in_i,
  output logic [XLEN-1:0] data_o
);
  // Replace only the field covered by the store size.
  always_comb begin
    data_o = data_l_i;
    case (funct3_i)
      F3_B: begin
        if (s_byte_i) data_o[15:8] = data_in_i[7:0];
        else          data_o[7:0]  = data_in_i[7:0];
      end
      F3_H:    data_o[15:0] = data_in_i[15:0];
      F3_W:    data_o[31:0] = data_in_i[31:0];
      F3_D:    data_o = data_in_i;
      default: data_o = data_l_i;
    endcase
  end
endmodule

module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_err,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic            mem_ack,
  input  logic [XLEN-1:0] mem_rdata
);
  typedef enum logic [1:0] {
    IDLE,
    RD,
    WR,
    RESP
  } state_e;

  state_e          state_q, state_d;
  logic            we_q, we_d;
  logic [2:0]      f3_q, f3_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [XLEN-1:0] word_q, word_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic            err_q, err_d;

  logic [XLEN-1:0] lu_out;
  logic [XLEN-1:0] su_out;
  logic [XLEN-1:0] resp_now;
  logic            bad_f3;
  logic            misal;

  lu #(.XLEN(XLEN)) u_lu (
    .s_byte_i (addr_q[0]),
    .funct3_i (f3_q),
    .data_i   (word_q),
    .data_o   (lu_out)
  );

  su #(.XLEN(XLEN)) u_su (
    .s_byte_i  (addr_q[0]),
    .funct3_i  (f3_q),
    .data_l_i  (word_q),
    .data_in_i (wdata_q),
    .data_o    (su_out)
  );

  // Classify the incoming request: undefined code or misaligned access.
  always_comb begin
    bad_f3 = req_we ? req_funct3[2] : (req_funct3 == 3'b111);
`ifdef LSU_MISALIGN_TRAP_EN
    if (req_we)
      misal = req_addr[0] &&
              (req_funct3 == F3_H || req_funct3 == F3_W);
    else
      misal = req_addr[0] &&
              (req_funct3 == F3_H || req_funct3 == F3_HU ||
               req_funct3 == F3_W || req_funct3 == F3_WU);
`else
    misal = 1'b0;
`endif
  end

  // Next-state and register update logic.
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    f3_d    = f3_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    word_d  = word_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          f3_d    = req_funct3;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          err_d   = bad_f3 | misal;
          if (bad_f3 | misal)
            state_d = RESP;
          else if (req_we && req_funct3 == F3_D)
            state_d = WR;
          else
            state_d = RD;
        end
      end
      RD: begin
        if (mem_ack) begin
          word_d  = mem_rdata;
          state_d = we_q ? WR : RESP;
        end
      end
      WR: begin
        if (mem_ack) state_d = RESP;
      end
      RESP: begin
        rdata_d = resp_now;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output decode from the current state.
  always_comb begin
    resp_now   = (we_q || err_q) ? '0 : lu_out;
    req_ready  = (state_q == IDLE);
    resp_valid = (state_q == RESP);
    resp_err   = (state_q == RESP) && err_q;
    resp_rdata = (state_q == RESP) ? resp_now : rdata_q;
    mem_req    = (state_q == RD) || (state_q == WR);
    mem_we     = (state_q == WR);
    mem_addr   = mem_req ? {addr_q[XLEN-1:1], 1'b0} : '0;
    mem_wdata  = (state_q == WR) ? su_out : '0;
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      word_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      word_q  <= word_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end
endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed testbench for lsu_ctrl.
// Inputs change and outputs are sampled on the falling edge.
module tb_lsu_ctrl;
  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  lsu_ctrl #(.XLEN(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present a request for one cycle; returns in the cycle after accept.
  task automatic issue(input logic we, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd);
    chk("ready_before_issue", {31'd0, req_ready}, 32'd1);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    @(negedge clk);
    req_valid  = 1'b0;
  endtask

  // Zero-wait load: read cycle, then response cycle, then idle.
  task automatic do_load(input string tag, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] rd,
                         input logic [31:0] exp);
    issue(1'b0, f3, a, 32'h0);
    chk({tag, "_rd_req"}, {31'd0, mem_req}, 32'd1);
    chk({tag, "_rd_addr"}, mem_addr, {a[31:1], 1'b0});
    mem_ack   = 1'b1;
    mem_rdata = rd;
    @(negedge clk);
    mem_ack   = 1'b0;
    chk({tag, "_valid"}, {31'd0, resp_valid}, 32'd1);
    chk({tag, "_rdata"}, resp_rdata, exp);
    chk({tag, "_err"}, {31'd0, resp_err}, 32'd0);
    @(negedge clk);
  endtask

  initial begin
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'b0;
    req_addr   = '0;
    req_wdata  = '0;
    mem_ack    = 1'b0;
    mem_rdata  = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset state
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_memreq", {31'd0, mem_req}, 32'd0);
    chk("rst_rdata", resp_rdata, 32'h0);

    // LB at 0x101
    issue(1'b0, 3'b000, 32'h101, 32'h0);
    chk("lb_memreq", {31'd0, mem_req}, 32'd1);
    chk("lb_memwe", {31'd0, mem_we}, 32'd0);
    chk("lb_addr", mem_addr, 32'h100);
    chk("lb_ready", {31'd0, req_ready}, 32'd0);
    mem_ack   = 1'b1;
    mem_rdata = 32'h0000_80FF;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("lb_valid", {31'd0, resp_valid}, 32'd1);
    chk("lb_rdata", resp_rdata, 32'hFFFF_FF80);
    chk("lb_memreq_resp", {31'd0, mem_req}, 32'd0);
    @(negedge clk);
    chk("lb_valid_drop", {31'd0, resp_valid}, 32'd0);
    chk("lb_hold", resp_rdata, 32'hFFFF_FF80);

    // SB at 0x201: read-modify-write
    issue(1'b1, 3'b000, 32'h201, 32'h0000_00AB);
    chk("sb_rd_req", {31'd0, mem_req}, 32'd1);
    chk("sb_rd_we", {31'd0, mem_we}, 32'd0);
    chk("sb_rd_addr", mem_addr, 32'h200);
    mem_ack   = 1'b1;
    mem_rdata = 32'h1234_5678;
    @(negedge clk);
    chk("sb_wr_we", {31'd0, mem_we}, 32'd1);
    chk("sb_wr_addr", mem_addr, 32'h200);
    chk("sb_wr_data", mem_wdata, 32'h1234_AB78);
    chk("sb_wr_novalid", {31'd0, resp_valid}, 32'd0);
    @(negedge clk);
    mem_ack = 1'b0;
    chk("sb_valid", {31'd0, resp_valid}, 32'd1);
    chk("sb_rdata", resp_rdata, 32'h0);
    chk("sb_err", {31'd0, resp_err}, 32'd0);
    @(negedge clk);

    // SD: single write, no read
    issue(1'b1, 3'b011, 32'h400, 32'hDEAD_BEEF);
    chk("sd_we", {31'd0, mem_we}, 32'd1);
    chk("sd_wdata", mem_wdata, 32'hDEAD_BEEF);
    chk("sd_addr", mem_addr, 32'h400);
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("sd_valid", {31'd0, resp_valid}, 32'd1);
    @(negedge clk);

    // LW with three wait cycles; a competing request is ignored
    issue(1'b0, 3'b010, 32'h10, 32'h0);
    mem_rdata = 32'hCAFE_0001;
    for (int i = 0; i < 3; i++) begin
      req_valid = 1'b1;
      req_addr  = 32'h500;
      chk("wait_req", {31'd0, mem_req}, 32'd1);
      chk("wait_addr", mem_addr, 32'h10);
      chk("wait_ready", {31'd0, req_ready}, 32'd0);
      chk("wait_valid", {31'd0, resp_valid}, 32'd0);
      @(negedge clk);
    end
    req_valid = 1'b0;
    chk("wait_addr_ack", mem_addr, 32'h10);
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("wait_valid_c5", {31'd0, resp_valid}, 32'd1);
    chk("wait_rdata", resp_rdata, 32'hCAFE_0001);
    @(negedge clk);

    // Sub-word loads
    do_load("lh", 3'b001, 32'h20, 32'h0001_8001, 32'hFFFF_8001);
    do_load("lhu", 3'b101, 32'h20, 32'h0001_8001, 32'h0000_8001);
    do_load("lbu", 3'b100, 32'h21, 32'h0000_80FF, 32'h0000_0080);

    // SH aligned
    issue(1'b1, 3'b001, 32'h30, 32'h0000_5566);
    mem_ack   = 1'b1;
    mem_rdata = 32'hAAAA_BBBB;
    @(negedge clk);
    chk("sh_wdata", mem_wdata, 32'hAAAA_5566);
    @(negedge clk);
    mem_ack = 1'b0;
    chk("sh_valid", {31'd0, resp_valid}, 32'd1);
    @(negedge clk);

    // Undefined funct3, load and store
    issue(1'b0, 3'b111, 32'h40, 32'h0);
    chk("undef_ld_valid", {31'd0, resp_valid}, 32'd1);
    chk("undef_ld_err", {31'd0, resp_err}, 32'd1);
    chk("undef_ld_memreq", {31'd0, mem_req}, 32'd0);
    chk("undef_ld_rdata", resp_rdata, 32'h0);
    @(negedge clk);
    issue(1'b1, 3'b101, 32'h40, 32'h1);
    chk("undef_st_valid", {31'd0, resp_valid}, 32'd1);
    chk("undef_st_err", {31'd0, resp_err}, 32'd1);
    chk("undef_st_memreq", {31'd0, mem_req}, 32'd0);
    @(negedge clk);
    chk("undef_idle_err", {31'd0, resp_err}, 32'd0);

    // Load leaves a non-zero held value before the reset test
    do_load("lbu2", 3'b100, 32'h21, 32'h0000_80FF, 32'h0000_0080);

    // Reset while in WR, then a late ack
    issue(1'b1, 3'b000, 32'h41, 32'h0000_0011);
    mem_ack   = 1'b1;
    mem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("rstwr_in_wr", {31'd0, mem_we}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstwr_ready", {31'd0, req_ready}, 32'd1);
    chk("rstwr_memreq", {31'd0, mem_req}, 32'd0);
    chk("rstwr_memwe", {31'd0, mem_we}, 32'd0);
    chk("rstwr_addr", mem_addr, 32'h0);
    chk("rstwr_wdata", mem_wdata, 32'h0);
    chk("rstwr_valid", {31'd0, resp_valid}, 32'd0);
    chk("rstwr_rdata", resp_rdata, 32'h0);
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("late_ack_valid", {31'd0, resp_valid}, 32'd0);
    chk("late_ack_memreq", {31'd0, mem_req}, 32'd0);
    @(negedge clk);

    // LW at 0x3 (misaligned)
    issue(1'b0, 3'b010, 32'h3, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
    chk("mis_valid", {31'd0, resp_valid}, 32'd1);
    chk("mis_err", {31'd0, resp_err}, 32'd1);
    chk("mis_memreq", {31'd0, mem_req}, 32'd0);
    chk("mis_rdata", resp_rdata, 32'h0);
    @(negedge clk);
`else
    chk("mis_memreq", {31'd0, mem_req}, 32'd1);
    chk("mis_addr", mem_addr, 32'h2);
    mem_ack   = 1'b1;
    mem_rdata = 32'h1122_3344;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("mis_valid", {31'd0, resp_valid}, 32'd1);
    chk("mis_err", {31'd0, resp_err}, 32'd0);
    chk("mis_rdata", resp_rdata, 32'h1122_3344);
    @(negedge clk);
`endif
    chk("end_ready", {31'd0, req_ready}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
